// File: rtl/ysyx_24110006_seq.sv
// ysyx_24110006_seq -- multi-cycle instruction sequencer.
//
// Owns the PC and steps each instruction through FETCH -> EXEC -> (MEM) -> WB.
// Instruction fetch and load/store use a req/ack handshake. EXEC and WB are
// single-cycle strobes into the combinational decode/execute datapath.
//
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   o_ifu_req/o_ifu_addr              fetch request and address (= o_pc)
//   i_ifu_ack/i_ifu_inst              fetch completion and instruction word
//   o_inst                            instruction register for decode/EXU
//   o_exu_en                          EXEC strobe; EXU outputs sampled here
//   i_result/i_jump/i_upc/i_reg_wen   EXU result, jump flag, target, reg write
//   o_lsu_req/o_lsu_wen/o_lsu_addr    memory request, store flag, address
//   i_lsu_ack                         memory access done
//   o_rf_wen/o_wb_sel_mem/o_wb_data   register write strobe, source, data
//   o_pc, o_halt, o_err, o_retired, o_state   status
module ysyx_24110006_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_ifu_req,
  output logic [31:0] o_ifu_addr,
  input  logic        i_ifu_ack,
  input  logic [31:0] i_ifu_inst,
  output logic [31:0] o_inst,
  output logic        o_exu_en,
  input  logic [31:0] i_result,
  input  logic        i_jump,
  input  logic [31:0] i_upc,
  input  logic        i_reg_wen,
  output logic        o_lsu_req,
  output logic        o_lsu_wen,
  output logic [31:0] o_lsu_addr,
  input  logic        i_lsu_ack,
  output logic        o_rf_wen,
  output logic        o_wb_sel_mem,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_pc,
  output logic        o_halt,
  output logic        o_err,
  output logic [31:0] o_retired,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Wait-counter value seen during the last permitted request cycle.
  localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_result;
  logic        r_jump;
  logic [31:0] r_upc;
  logic        r_wen;
  logic        r_is_load;
  logic        r_is_store;
  logic [31:0] r_retired;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_next;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_ebreak;
  logic        w_is_wb;
  logic [31:0] w_next_pc;

  // Opcode classification of the latched instruction.
  always_comb begin
    w_is_load   = (r_inst[6:0] == 7'b0000011);
    w_is_store  = (r_inst[6:0] == 7'b0100011);
    w_is_ebreak = (r_inst == 32'h0010_0073);
    w_is_wb     = 1'b0;
    case (r_inst[6:0])
      7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111,
      7'b0010111, 7'b0110111, 7'b1100011: w_is_wb = 1'b1;
      default:                            w_is_wb = 1'b0;
    endcase
  end

  // Jump targets are halfword-aligned by clearing bit 0; bit 1 is checked in WB.
  assign w_next_pc = r_jump ? (r_upc & ~32'h1) : (r_pc + 32'd4);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    case (r_state)
      S_FETCH: begin
        if (i_ifu_ack) begin
          w_state_next = S_EXEC;
          w_wait_next  = 16'd0;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_state_next = S_ERR;
        end else begin
          w_wait_next = r_wait_cnt + 16'd1;
        end
      end
      S_EXEC: begin
        // Counter restarts so that MEM sees a fresh budget.
        w_wait_next = 16'd0;
        if (w_is_ebreak)                  w_state_next = S_HALT;
        else if (w_is_load || w_is_store) w_state_next = S_MEM;
        else if (w_is_wb)                 w_state_next = S_WB;
        else                              w_state_next = S_ERR;
      end
      S_MEM: begin
        if (i_lsu_ack) begin
          w_state_next = S_WB;
          w_wait_next  = 16'd0;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_state_next = S_ERR;
        end else begin
          w_wait_next = r_wait_cnt + 16'd1;
        end
      end
      S_WB: begin
        w_wait_next  = 16'd0;
        w_state_next = w_next_pc[1] ? S_ERR : S_FETCH;
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_inst     <= 32'd0;
      r_result   <= 32'd0;
      r_jump     <= 1'b0;
      r_upc      <= 32'd0;
      r_wen      <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_retired  <= 32'd0;
      r_wait_cnt <= 16'd0;
    end else begin
      r_wait_cnt <= w_wait_next;
      case (r_state)
        S_FETCH: begin
          if (i_ifu_ack) r_inst <= i_ifu_inst;
        end
        S_EXEC: begin
          r_result   <= i_result;
          r_jump     <= i_jump;
          r_upc      <= i_upc;
          r_wen      <= i_reg_wen;
          r_is_load  <= w_is_load;
          r_is_store <= w_is_store;
        end
        S_WB: begin
          // A misaligned next PC leaves o_pc at the faulting instruction.
          if (!w_next_pc[1]) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // All handshake and strobe outputs decode from registered state only.
  assign o_ifu_req    = (r_state == S_FETCH);
  assign o_ifu_addr   = r_pc;
  assign o_inst       = r_inst;
  assign o_exu_en     = (r_state == S_EXEC);
  assign o_lsu_req    = (r_state == S_MEM);
  assign o_lsu_wen    = r_is_store;
  assign o_lsu_addr   = r_result;
  assign o_rf_wen     = (r_state == S_WB) && r_wen;
  assign o_wb_sel_mem = (r_state == S_WB) && r_is_load;
  assign o_wb_data    = r_result;
  assign o_pc         = r_pc;
  assign o_halt       = (r_state == S_HALT);
  assign o_err        = (r_state == S_ERR);
  assign o_retired    = r_retired;
  assign o_state      = r_state;

endmodule

// File: tb/tb_ysyx_24110006_seq.sv
// tb_ysyx_24110006_seq -- self-checking bench for the instruction sequencer.
// A main instance (TIMEOUT=255) runs directed and random instruction streams
// against a per-instruction reference model; a second instance (TIMEOUT=4)
// covers the request timeout behaviour.
module tb_ysyx_24110006_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        ifu_ack, lsu_ack;
  logic        t_ifu_ack, t_lsu_ack;
  logic [31:0] ifu_inst, result, upc;
  logic        jump, reg_wen;

  logic        d_ifu_req, d_exu_en, d_lsu_req, d_lsu_wen, d_rf_wen, d_wb_sel_mem, d_halt, d_err;
  logic [31:0] d_ifu_addr, d_inst, d_lsu_addr, d_wb_data, d_pc, d_retired;
  logic [2:0]  d_state;
  logic        t_ifu_req, t_exu_en, t_lsu_req, t_lsu_wen, t_rf_wen, t_wb_sel_mem, t_halt, t_err;
  logic [31:0] t_ifu_addr, t_inst, t_lsu_addr, t_wb_data, t_pc, t_retired;
  logic [2:0]  t_state;

  int vectors;
  int miscompares;
  logic [31:0] m_pc;
  logic [31:0] m_retired;

  ysyx_24110006_seq dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_ifu_req(d_ifu_req), .o_ifu_addr(d_ifu_addr), .i_ifu_ack(ifu_ack), .i_ifu_inst(ifu_inst),
    .o_inst(d_inst), .o_exu_en(d_exu_en),
    .i_result(result), .i_jump(jump), .i_upc(upc), .i_reg_wen(reg_wen),
    .o_lsu_req(d_lsu_req), .o_lsu_wen(d_lsu_wen), .o_lsu_addr(d_lsu_addr), .i_lsu_ack(lsu_ack),
    .o_rf_wen(d_rf_wen), .o_wb_sel_mem(d_wb_sel_mem), .o_wb_data(d_wb_data),
    .o_pc(d_pc), .o_halt(d_halt), .o_err(d_err), .o_retired(d_retired), .o_state(d_state)
  );

  ysyx_24110006_seq #(.TIMEOUT(4)) dut_t (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_ifu_req(t_ifu_req), .o_ifu_addr(t_ifu_addr), .i_ifu_ack(t_ifu_ack), .i_ifu_inst(ifu_inst),
    .o_inst(t_inst), .o_exu_en(t_exu_en),
    .i_result(result), .i_jump(jump), .i_upc(upc), .i_reg_wen(reg_wen),
    .o_lsu_req(t_lsu_req), .o_lsu_wen(t_lsu_wen), .o_lsu_addr(t_lsu_addr), .i_lsu_ack(t_lsu_ack),
    .o_rf_wen(t_rf_wen), .o_wb_sel_mem(t_wb_sel_mem), .o_wb_data(t_wb_data),
    .o_pc(t_pc), .o_halt(t_halt), .o_err(t_err), .o_retired(t_retired), .o_state(t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifu_ack = 1'b0; lsu_ack = 1'b0; t_ifu_ack = 1'b0; t_lsu_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", d_state, 0);
    check("rst_ifu_req", d_ifu_req, 1);
    check("rst_pc", d_pc, RST_PC);
    check("rst_inst", d_inst, 0);
    check("rst_retired", d_retired, 0);
    check("rst_strobes", {d_exu_en, d_lsu_req, d_rf_wen, d_halt, d_err}, 0);
    rst_n = 1'b1;
    m_pc = RST_PC;
    m_retired = 0;
  endtask

  // Terminal states: nothing moves and nothing is requested, whatever the acks do.
  task automatic terminal_check(input logic [2:0] exp_state);
    for (int k = 0; k < 3; k++) begin
      check("term_state", d_state, exp_state);
      check("term_halt_err", {d_halt, d_err}, (exp_state == 3'd4) ? 2'b10 : 2'b01);
      check("term_strobes", {d_ifu_req, d_exu_en, d_lsu_req, d_rf_wen}, 0);
      check("term_pc", d_pc, m_pc);
      check("term_retired", d_retired, m_retired);
      ifu_ack = 1'($urandom_range(0, 1));
      lsu_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ifu_ack = 1'b0; lsu_ack = 1'b0;
  endtask

  // Reference model for one instruction, starting at the negedge of its first FETCH cycle.
  task automatic run_insn(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] up,
                          input logic jmp, input logic wen, input int fwait, input int lwait);
    logic [6:0]  op;
    logic        ld, st, wbop;
    logic [31:0] npc;
    op   = inst[6:0];
    ld   = (op == 7'h03);
    st   = (op == 7'h23);
    wbop = (op == 7'h13) || (op == 7'h33) || (op == 7'h6f) || (op == 7'h67) ||
           (op == 7'h17) || (op == 7'h37) || (op == 7'h63);
    for (int k = 0; k <= fwait; k++) begin
      check("fetch_state", d_state, 0);
      check("fetch_req", d_ifu_req, 1);
      check("fetch_addr", d_ifu_addr, m_pc);
      check("fetch_quiet", {d_exu_en, d_lsu_req, d_rf_wen}, 0);
      ifu_ack  = (k == fwait);
      ifu_inst = (k == fwait) ? inst : $urandom;
      lsu_ack  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ifu_ack = 1'b0; lsu_ack = 1'b0;
    check("exec_state", d_state, 1);
    check("exec_en", d_exu_en, 1);
    check("exec_inst", d_inst, inst);
    check("exec_quiet", {d_ifu_req, d_lsu_req, d_rf_wen}, 0);
    result = res; upc = up; jump = jmp; reg_wen = wen; ifu_inst = $urandom;
    @(negedge clk);
    // Scramble EXU outputs: only the EXEC-cycle values may be used from here on.
    result = $urandom; upc = $urandom; jump = 1'($urandom_range(0, 1)); reg_wen = 1'($urandom_range(0, 1));
    if (inst == 32'h0010_0073) begin
      terminal_check(3'd4);
      return;
    end
    if (!(ld || st || wbop)) begin
      terminal_check(3'd5);
      return;
    end
    if (ld || st) begin
      for (int k = 0; k <= lwait; k++) begin
        check("mem_state", d_state, 2);
        check("mem_req", d_lsu_req, 1);
        check("mem_wen", d_lsu_wen, st);
        check("mem_addr", d_lsu_addr, res);
        check("mem_quiet", {d_ifu_req, d_rf_wen}, 0);
        lsu_ack = (k == lwait);
        ifu_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      lsu_ack = 1'b0; ifu_ack = 1'b0;
    end
    check("wb_state", d_state, 3);
    check("wb_rf_wen", d_rf_wen, wen);
    check("wb_sel_mem", d_wb_sel_mem, ld);
    check("wb_data", d_wb_data, res);
    check("wb_quiet", {d_ifu_req, d_lsu_req, d_exu_en}, 0);
    npc = jmp ? {up[31:1], 1'b0} : (m_pc + 32'd4);
    @(negedge clk);
    if (npc[1]) begin
      terminal_check(3'd5);
    end else begin
      m_pc = npc;
      m_retired = m_retired + 32'd1;
      check("next_pc", d_pc, m_pc);
      check("retired", d_retired, m_retired);
      check("next_fetch", d_ifu_req, 1);
    end
  endtask

  initial begin
    logic [31:0] rnd, inst, up;
    logic [6:0]  op;
    int          sel;
    vectors = 0; miscompares = 0;
    ifu_inst = 32'd0; result = 32'd0; upc = 32'd0; jump = 1'b0; reg_wen = 1'b0;
    m_pc = RST_PC; m_retired = 0;

    do_reset();
    run_insn(32'h0050_0093, 32'h0000_0005, 32'd0, 1'b0, 1'b1, 0, 0);           // addi
    run_insn(32'h0000_a103, 32'h8000_1000, 32'd0, 1'b0, 1'b1, 0, 4);           // lw, 5 req cycles
    run_insn(32'h0020_a023, 32'h8000_2004, 32'd0, 1'b0, 1'b0, 1, 0);           // sw
    run_insn(32'h0000_80e7, 32'h8000_0010, 32'h8000_0101, 1'b1, 1'b1, 0, 0);   // jalr
    check("jalr_pc", d_pc, 32'h8000_0100);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 8);
      case (sel)
        0: op = 7'h03; 1: op = 7'h23; 2: op = 7'h13; 3: op = 7'h33; 4: op = 7'h6f;
        5: op = 7'h67; 6: op = 7'h17; 7: op = 7'h37; default: op = 7'h63;
      endcase
      rnd  = $urandom;
      inst = {rnd[31:7], op};
      rnd  = $urandom;
      up   = {rnd[31:2], 1'b0, rnd[0]};
      run_insn(inst, $urandom, up, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    run_insn(32'h0000_80e7, 32'h0, 32'h8000_0102, 1'b1, 1'b1, 0, 0);          // misaligned jalr -> ERR

    do_reset();
    run_insn(32'h0010_0073, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0);                  // ebreak -> HALT
    do_reset();
    run_insn(32'h0000_0073, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0);                  // ecall -> ERR

    // Reset aborts a pending load.
    do_reset();
    run_insn(32'h0050_0093, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0);
    ifu_ack = 1'b1; ifu_inst = 32'h0000_a103;
    @(negedge clk);
    ifu_ack = 1'b0; result = 32'h8000_3000; reg_wen = 1'b1; jump = 1'b0;
    @(negedge clk);
    check("abort_in_mem", d_lsu_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_lsu_req", d_lsu_req, 0);
    check("abort_pc", d_pc, RST_PC);
    check("abort_retired", d_retired, 0);
    check("abort_ifu_req", d_ifu_req, 1);
    lsu_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_strobe", {d_rf_wen, d_lsu_req, d_exu_en}, 0);
    end
    lsu_ack = 1'b0;

    // TIMEOUT=4: withheld fetch ack errors after 4 request cycles.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      check("tmo_fetch_req", t_ifu_req, 1);
      @(negedge clk);
    end
    check("tmo_fetch_err", t_err, 1);
    check("tmo_fetch_state", t_state, 5);
    check("tmo_fetch_quiet", t_ifu_req, 0);
    t_ifu_ack = 1'b1;
    @(negedge clk);
    t_ifu_ack = 1'b0;
    check("tmo_err_sticky", t_err, 1);

    // Ack in the 4th fetch cycle is accepted; then a withheld LSU ack times out.
    do_reset();
    ifu_inst = 32'h0000_a103;
    for (int k = 1; k <= 4; k++) begin
      check("tmo_late_req", t_ifu_req, 1);
      t_ifu_ack = (k == 4);
      @(negedge clk);
    end
    t_ifu_ack = 1'b0;
    check("tmo_late_exec", t_exu_en, 1);
    check("tmo_late_inst", t_inst, 32'h0000_a103);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      check("tmo_mem_req", t_lsu_req, 1);
      @(negedge clk);
    end
    check("tmo_mem_err", t_err, 1);
    check("tmo_mem_pc", t_pc, RST_PC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
